mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator between the CPU datapath and the word-organised `data_memory`. It accepts one byte, halfword or word request at a time over a valid/ready handshake. It drives the memory's `W_en`/`R_en`/`addr`/`din` and reads `dout`. Sub-word stores are turned into a read-modify-write, and sub-word loads are sign- or zero-extended. Misaligned or out-of-range requests return an error response with no memory access.

## Interface
Parameters:
- `MEM_BYTES`, default 1024: byte size of the attached memory (256 words); any request with `addr >= MEM_BYTES` is an error.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: single clock, rising edge.
  - `rst` in 1: synchronous, active-high reset.
- Request:
  - `req_valid` in 1: request present.
  - `req_ready` out 1: high only in IDLE.
  - `req_we` in 1: 1 = store, 0 = load.
  - `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
  - `req_unsigned` in 1: zero-extend loads (ignored for stores).
  - `req_addr` in 32: byte address.
  - `req_wdata` in 32: store data, right-aligned.
- Response:
  - `rsp_valid` out 1: one-cycle response pulse, no backpressure.
  - `rsp_rdata` out 32: extended load data; 0 for stores and errors.
  - `rsp_err` out 1: request rejected, valid with `rsp_valid`.
- Memory side:
  - `mem_W_en` out 1: memory write enable.
  - `mem_R_en` out 1: memory read enable.
  - `mem_addr` out 32: `{lat_addr[31:2],2'b00}`.
  - `mem_din` out 32: word to write.
  - `mem_dout` in 32: combinational read data from memory.

## Operation
- Handshake: a request is accepted on an edge where `req_valid && req_ready`. `addr`, `we`, `size`, `unsigned` and `wdata` are latched at that edge.
- Error check at accept. Any one of these conditions makes the request an error:
  - `size==11`
  - half with `addr[0]==1`
  - word with `addr[1:0]!=0`
  - `addr >= MEM_BYTES`
- Byte lanes are little-endian: byte lane = `addr[1:0]`, half lane = `addr[1]`.
- FSM states and transitions:
  - IDLE: `req_ready=1`. On accept, go to:
    - RESP if error;
    - LOAD if load;
    - WRITE if store word;
    - MERGE if store byte/half.
  - LOAD: `mem_R_en=1`. Capture the extracted, extended lane into `rsp_rdata`, then go to RESP.
  - MERGE: `mem_R_en=1`. Capture `mem_dout` with the addressed lane replaced by `wdata[7:0]` or `wdata[15:0]`, then go to WRITE.
  - WRITE: `mem_W_en=1`, `mem_din` = merged word (sub-word store) or `wdata` (word store). Then go to RESP.
  - RESP: `rsp_valid=1` for exactly one cycle, with `rsp_err` set for errors. Then go to IDLE.
- `mem_W_en` and `mem_R_en` are decoded from the state only; they are 0 in IDLE, RESP and on error paths.
- `mem_W_en` is gated with `!rst`, so an asserted reset never writes memory.

## Timing
- Accept edge ends cycle 0. Response (`rsp_valid`) is visible in:
  - error: cycle 1;
  - load: cycle 2;
  - word store: cycle 2;
  - sub-word store: cycle 3.
- Memory write occurs at the end of the WRITE cycle:
  - word store: cycle 1;
  - sub-word store: cycle 2.
- No overlap between requests. The next accept is possible in the cycle after RESP, so peak load throughput is 1 per 3 cycles.
- Reset (rst high at an edge):
  - state goes to IDLE;
  - `rsp_valid`, `rsp_err`, `rsp_rdata` and latched registers clear to 0;
  - `mem_W_en`/`mem_R_en` are 0;
  - `req_ready` is 1 from the first cycle after reset deasserts.
- Reset mid-operation: an in-flight request is dropped with no response and no write. This includes reset asserted during WRITE.
- `rsp_rdata` holds its value until the next RESP or reset.

## Structure
- Package `mau_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - FSM state encoding `ST_IDLE`/`ST_LOAD`/`ST_MERGE`/`ST_WRITE`/`ST_RESP`.
- Sub-module `mau_lane`, purely combinational:
  - load extract plus sign/zero extension from (`word`, `addr[1:0]`, `size`, `unsigned`);
  - store merge from (`old_word`, `wdata`, `addr[1:0]`, `size`).
- The top level holds the FSM, the request latch and the response registers.

## Test plan
- Word store/load: store word `0xDEADBEEF` at `0x10`, then load word `0x10`.
  - Expect `mem_W_en` in cycle 1 and `rsp_valid` in cycle 2.
  - Load returns `rsp_rdata=0xDEADBEEF`, `rsp_err=0`, `rsp_valid` in cycle 2.
- Byte read-modify-write and extension: with `0x11223344` at `0x10`, store byte `0xAA` to `0x11`.
  - MERGE shows `R_en`, WRITE writes `0x1122AA44`, `rsp_valid` in cycle 3.
  - Signed byte load of `0x11` returns `0xFFFFFFAA`; unsigned returns `0x000000AA`.
- Halfword: with `0x8001ABCD` at `0x20`:
  - signed half load of `0x22` returns `0xFFFF8001`;
  - unsigned half load of `0x20` returns `0x0000ABCD`.
- Errors: each case returns `rsp_err=1` with `rsp_valid` in cycle 1 and no `R_en`/`W_en` pulse.
  - word load at `0x13`;
  - half store at `0x05`;
  - `req_size=11`;
  - word load at `0x400`.
- Reset mid-store: assert `rst` during MERGE or WRITE of a byte store.
  - No `mem_W_en` high cycle, memory word unchanged, no `rsp_valid`.
  - `req_ready=1` in the cycle after reset deasserts.
- Back-to-back: hold `req_valid=1` with three queued loads.
  - Accepts occur only in IDLE cycles, spaced 3 cycles apart.
  - Exactly three `rsp_valid` pulses, in order, with correct data.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings for the load/store unit: request size codes and FSM states.
package mau_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

endpackage

// File: rtl/mau_lane.sv
// Little-endian lane logic: load extraction with sign/zero extension, and
// sub-word store merge into the word read back from memory.
module mau_lane
   import mau_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [15:0] i_wdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sext_b;
   logic        w_sext_h;

   always_comb begin
      w_byte   = i_word[{i_addr_lo, 3'b000} +: 8];
      w_half   = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
      w_sext_b = !i_unsigned && w_byte[7];
      w_sext_h = !i_unsigned && w_half[15];

      case (i_size)
         SZ_BYTE: o_load_data = {{24{w_sext_b}}, w_byte};
         SZ_HALF: o_load_data = {{16{w_sext_h}}, w_half};
         default: o_load_data = i_word;
      endcase

      o_merged = i_word;
      case (i_size)
         SZ_BYTE: o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
         SZ_HALF: begin
            if (i_addr_lo[1]) o_merged[31:16] = i_wdata;
            else              o_merged[15:0]  = i_wdata;
         end
         default: o_merged = i_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-organised data memory: one request at a
// time, read-modify-write for sub-word stores, error response with no access.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_W_en,
   output logic        mem_R_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   localparam logic [31:0] LP_LIMIT = 32'(MEM_BYTES);

   state_t      r_state;
   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [31:0] r_wword;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [31:0] r_rsp_rdata;

   logic        w_err;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;

   always_comb begin
      w_err = (req_size == SZ_ILL)
           || (req_size == SZ_HALF && req_addr[0])
           || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
           || (req_addr >= LP_LIMIT);
   end

   mau_lane u_lane (
      .i_word      (mem_dout),
      .i_wdata     (r_wword[15:0]),
      .i_addr_lo   (r_addr[1:0]),
      .i_size      (r_size),
      .i_unsigned  (r_unsigned),
      .o_load_data (w_load_data),
      .o_merged    (w_merged)
   );

   // r_wword holds the store data until MERGE overwrites it with the merged word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_size      <= '0;
         r_unsigned  <= 1'b0;
         r_wword     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_addr     <= req_addr;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_wword    <= req_wdata;
                  if (w_err) begin
                     r_state     <= ST_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else if (!req_we) begin
                     r_state <= ST_LOAD;
                  end else if (req_size == SZ_WORD) begin
                     r_state <= ST_WRITE;
                  end else begin
                     r_state <= ST_MERGE;
                  end
               end
            end
            ST_LOAD: begin
               r_rsp_rdata <= w_load_data;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_MERGE: begin
               r_wword <= w_merged;
               r_state <= ST_WRITE;
            end
            ST_WRITE: begin
               r_rsp_rdata <= '0;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
   assign mem_R_en  = (r_state == ST_LOAD) || (r_state == ST_MERGE);
   assign mem_W_en  = (r_state == ST_WRITE) && !rst;
   assign mem_addr  = {r_addr[31:2], 2'b00};
   assign mem_din   = r_wword;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory attached.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_W_en;
   logic        mem_R_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   logic [31:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   mem_access_unit #(.MEM_BYTES(1024)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_W_en     (mem_W_en),
      .mem_R_en     (mem_R_en),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout)
   );

   always #5 clk = ~clk;

   assign mem_dout = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_W_en) mem[mem_addr[9:2]] <= mem_din;

   // Issues one request and records, per cycle after the accept edge, the
   // enables seen and the first response.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int rcyc, output logic err, output logic [31:0] rd,
                         output logic [7:0] wmask, output logic [7:0] rmask);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rcyc = 0; err = 1'b0; rd = '0; wmask = '0; rmask = '0;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         if (mem_W_en) wmask[k] = 1'b1;
         if (mem_R_en) rmask[k] = 1'b1;
         if (rsp_valid && rcyc == 0) begin
            rcyc = k; err = rsp_err; rd = rsp_rdata;
         end
      end
      $display("req we=%0b size=%0d uns=%0b addr=%h wdata=%h -> rsp_cyc=%0d err=%0b rdata=%h wmask=%b rmask=%b",
               we, sz, uns, a, wd, rcyc, err, rd, wmask, rmask);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
      checks++; if (mem_W_en !== 1'b0 || mem_R_en !== 1'b0) begin errors++; $display("FAIL reset_enables: got W=%b R=%b expected 0 0", mem_W_en, mem_R_en); end
   endtask

   task automatic test_word();
      int rc; logic e; logic [31:0] rd; logic [7:0] wm, rm;
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rc, e, rd, wm, rm);
      checks++; if (rc !== 2) begin errors++; $display("FAIL wstore_rsp_cycle: got %0d expected 2", rc); end
      checks++; if (wm !== 8'b0000_0010 || rm !== 8'b0) begin errors++; $display("FAIL wstore_enables: got w=%b r=%b expected 00000010 00000000", wm, rm); end
      checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wstore_rsp: got err=%b rdata=%h expected 0 0", e, rd); end
      checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wstore_mem: got %h expected deadbeef", mem[4]); end
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rc, e, rd, wm, rm);
      checks++; if (rc !== 2) begin errors++; $display("FAIL wload_rsp_cycle: got %0d expected 2", rc); end
      checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL wload_data: got %h err=%b expected deadbeef 0", rd, e); end
      checks++; if (rm !== 8'b0000_0010 || wm !== 8'b0) begin errors++; $display("FAIL wload_enables: got r=%b w=%b expected 00000010 00000000", rm, wm); end
   endtask

   task automatic test_byte();
      int rc; logic e; logic [31:0] rd; logic [7:0] wm, rm;
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rc, e, rd, wm, rm);
      do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, rc, e, rd, wm, rm);
      checks++; if (rc !== 3) begin errors++; $display("FAIL bstore_rsp_cycle: got %0d expected 3", rc); end
      checks++; if (rm !== 8'b0000_0010 || wm !== 8'b0000_0100) begin errors++; $display("FAIL bstore_enables: got r=%b w=%b expected 00000010 00000100", rm, wm); end
      checks++; if (mem[4] !== 32'h1122AA44) begin errors++; $display("FAIL bstore_mem: got %h expected 1122aa44", mem[4]); end
      do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rc, e, rd, wm, rm);
      checks++; if (rd !== 32'hFFFFFFAA || rc !== 2) begin errors++; $display("FAIL bload_signed: got %h cyc=%0d expected ffffffaa 2", rd, rc); end
      checks++; if (rsp_rdata !== 32'hFFFFFFAA) begin errors++; $display("FAIL rdata_hold: got %h expected ffffffaa", rsp_rdata); end
      do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rc, e, rd, wm, rm);
      checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL bload_unsigned: got %h expected 000000aa", rd); end
   endtask

   task automatic test_half();
      int rc; logic e; logic [31:0] rd; logic [7:0] wm, rm;
      do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h8001ABCD, rc, e, rd, wm, rm);
      do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rc, e, rd, wm, rm);
      checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL hload_signed: got %h expected ffff8001", rd); end
      do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rc, e, rd, wm, rm);
      checks++; if (rd !== 32'h0000ABCD) begin errors++; $display("FAIL hload_unsigned: got %h expected 0000abcd", rd); end
      do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h00007E57, rc, e, rd, wm, rm);
      checks++; if (mem[8] !== 32'h7E57ABCD || rc !== 3) begin errors++; $display("FAIL hstore_upper: got %h cyc=%0d expected 7e57abcd 3", mem[8], rc); end
   endtask

   task automatic test_errors();
      logic        t_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [1:0]  t_sz   [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
      logic [31:0] t_addr [4] = '{32'h13, 32'h05, 32'h00, 32'h400};
      int rc; logic e; logic [31:0] rd; logic [7:0] wm, rm;
      for (int i = 0; i < 4; i++) begin
         do_req(t_we[i], t_sz[i], 1'b0, t_addr[i], 32'h5A5A5A5A, rc, e, rd, wm, rm);
         checks++; if (e !== 1'b1 || rc !== 1) begin errors++; $display("FAIL err_case%0d_rsp: got err=%b cyc=%0d expected 1 1", i, e, rc); end
         checks++; if (wm !== 8'b0 || rm !== 8'b0 || rd !== 32'h0) begin errors++; $display("FAIL err_case%0d_access: got w=%b r=%b rdata=%h expected none", i, wm, rm, rd); end
      end
   endtask

   task automatic test_reset_mid_store();
      int rc; logic e; logic [31:0] rd; logic [7:0] wm, rm;
      int seen_w; int seen_v;
      do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, rc, e, rd, wm, rm);
      for (int v = 0; v < 2; v++) begin
         seen_w = 0; seen_v = 0;
         @(negedge clk);
         req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h31; req_wdata = 32'h000000EE;
         @(posedge clk); #1 req_valid = 1'b0;
         if (v == 1) begin
            @(negedge clk);
            if (mem_W_en) seen_w++;
            @(posedge clk); #1;
         end
         rst = 1'b1;
         @(negedge clk);
         if (mem_W_en) seen_w++;
         if (rsp_valid) seen_v++;
         @(posedge clk); #1 rst = 1'b0;
         @(negedge clk);
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid%0d_ready: got %b expected 1", v, req_ready); end
         for (int k = 0; k < 4; k++) begin
            if (mem_W_en) seen_w++;
            if (rsp_valid) seen_v++;
            @(negedge clk);
         end
         $display("reset mid-store variant %0d: W_en cycles=%0d rsp pulses=%0d mem=%h", v, seen_w, seen_v, mem[12]);
         checks++; if (seen_w !== 0 || seen_v !== 0) begin errors++; $display("FAIL rstmid%0d_activity: got W_en=%0d rsp=%0d expected 0 0", v, seen_w, seen_v); end
         checks++; if (mem[12] !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid%0d_mem: got %h expected cafef00d", v, mem[12]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  b_sz   [3] = '{2'b10, 2'b01, 2'b00};
      logic        b_uns  [3] = '{1'b0, 1'b0, 1'b1};
      logic [31:0] b_addr [3] = '{32'h10, 32'h22, 32'h11};
      logic [31:0] b_exp  [3] = '{32'h1122AA44, 32'h00007E57, 32'h000000AA};
      logic [31:0] got [3];
      int acc [3];
      int idx; int nrsp; logic acc_now;
      idx = 0; nrsp = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = b_sz[0]; req_unsigned = b_uns[0]; req_addr = b_addr[0];
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge clk);
         if (rsp_valid) begin
            if (nrsp < 3) got[nrsp] = rsp_rdata;
            nrsp++;
         end
         acc_now = req_valid && req_ready;
         @(posedge clk); #1;
         if (acc_now && idx < 3) begin
            acc[idx] = c; idx++;
            if (idx < 3) begin
               req_size = b_sz[idx]; req_unsigned = b_uns[idx]; req_addr = b_addr[idx];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      checks++; if (idx !== 3 || nrsp !== 3) begin errors++; $display("FAIL b2b_counts: got accepts=%0d rsp=%0d expected 3 3", idx, nrsp); end
      if (idx == 3) begin
         checks++; if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d %0d %0d expected spacing 3", acc[0], acc[1], acc[2]); end
      end
      for (int i = 0; i < 3; i++) begin
         if (i < nrsp) begin
            $display("b2b rsp %0d: rdata=%h expected %h", i, got[i], b_exp[i]);
            checks++; if (got[i] !== b_exp[i]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, got[i], b_exp[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_reset_mid_store();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
